// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: loader byte writes vs. CPU word fetches.
// BOOT stalls the CPU until l_done; RUN arbitrates with a fetch starvation guard.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   l_valid/l_addr/l_data loader byte-write request; l_ready accepts it
//   l_done                one-cycle pulse, program fully loaded
//   f_req/f_addr          fetch request (even byte address); f_gnt accepts it
//   f_valid/f_instr       fetched word, one cycle after grant
//   f_err                 misaligned-fetch pulse, one cycle after grant
//   cpu_stall             high while booting
//   mem_*                 single memory port (1-cycle registered read data)
module imem_port_arbiter #(
  parameter int BUS_WIDTH = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l_valid,
  input  logic [BUS_WIDTH-1:0] l_addr,
  input  logic [7:0]           l_data,
  output logic                 l_ready,
  input  logic                 l_done,
  input  logic                 f_req,
  input  logic [BUS_WIDTH-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_valid,
  output logic [BUS_WIDTH-1:0] f_instr,
  output logic                 f_err,
  output logic                 cpu_stall,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       rd_pend;
  logic       err_pend;

  logic in_run;
  logic starved;
  logic odd;
  logic f_win;
  logic l_win;

  always_comb begin
    in_run  = (state == RUN) && !rst;
    starved = f_req && (wait_cnt == WAIT_MAX);
    odd     = f_addr[0];
    // In BOOT fetch never wins, so the loader takes any valid write.
    f_win   = in_run && f_req && (starved || !l_valid);
    l_win   = !rst && l_valid && !f_win;
  end

  always_comb begin
    l_ready   = l_win;
    f_gnt     = f_win;
    mem_wr_en = l_win;
    // A misaligned fetch is granted but never touches memory.
    mem_rd_en = f_win && !odd;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      mem_wr_en: begin
        mem_addr  = l_addr;
        mem_wdata = l_data;
      end
      mem_rd_en: begin
        mem_addr  = f_addr;
      end
      default: begin
      end
    endcase
  end

  // Reset drops any in-flight read or error immediately.
  assign f_valid   = rd_pend && !rst;
  assign f_err     = err_pend && !rst;
  assign f_instr   = mem_rdata;
  assign cpu_stall = (state == BOOT) || rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      rd_pend  <= mem_rd_en;
      err_pend <= f_win && odd;
      if (state == BOOT) begin
        wait_cnt <= '0;
        if (l_done) begin
          state <= RUN;
        end
      end else if (f_win || !f_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule
